// File: rtl/time_keeper.sv
// HH:MM:SS timekeeper with a 1 Hz prescaler, a load port for the time setter,
// and a daily alarm that rings until acknowledged, disarmed or timed out.
module time_keeper #(
   parameter int TICK_DIV  = 50000000,
   parameter int RING_SECS = 60
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       HOLD,
   input  logic       LOAD,
   input  logic [6:0] LD_HOUR,
   input  logic [6:0] LD_MIN,
   input  logic [6:0] LD_SEC,
   input  logic       ALM_EN,
   input  logic [6:0] ALM_HOUR,
   input  logic [6:0] ALM_MIN,
   input  logic       OK,
   output logic [6:0] HOUR,
   output logic [6:0] MIN,
   output logic [6:0] SEC,
   output logic       SEC_TICK,
   output logic       RING
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [7:0]    RING_LIM  = 8'(RING_SECS);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_DONE    = 2'd2
   } alm_state_e;

   logic [PW-1:0] presc_q, presc_d;
   logic [6:0]    hour_q, hour_d;
   logic [6:0]    min_q, min_d;
   logic [6:0]    sec_q, sec_d;
   logic          tick_q, tick_d;
   alm_state_e    state_q, state_d;
   logic          ring_q, ring_d;
   logic [6:0]    cnt_q, cnt_d;
   logic          match;
   logic [7:0]    cnt_inc;

   // LOAD beats HOLD, and both beat the tick; a swallowed tick is simply lost.
   always_comb begin
      presc_d = presc_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      tick_d  = 1'b0;
      if (LOAD) begin
         presc_d = '0;
         hour_d  = (LD_HOUR > 7'd23) ? 7'd0 : LD_HOUR;
         min_d   = (LD_MIN  > 7'd59) ? 7'd0 : LD_MIN;
         sec_d   = (LD_SEC  > 7'd59) ? 7'd0 : LD_SEC;
      end else if (!HOLD) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (sec_q == 7'd59) begin
               sec_d = 7'd0;
               if (min_q == 7'd59) begin
                  min_d  = 7'd0;
                  hour_d = (hour_q == 7'd23) ? 7'd0 : hour_q + 7'd1;
               end else begin
                  min_d = min_q + 7'd1;
               end
            end else begin
               sec_d = sec_q + 7'd1;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // Match uses the registered time, so a LOAD straight onto the alarm time rings too.
   always_comb begin
      match   = ALM_EN && (hour_q == ALM_HOUR) && (min_q == ALM_MIN) && (sec_q == 7'd0);
      cnt_inc = {1'b0, cnt_q} + {7'd0, tick_q};
      state_d = state_q;
      ring_d  = ring_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            ring_d = 1'b0;
            if (match) begin
               state_d = ST_RINGING;
               ring_d  = 1'b1;
               cnt_d   = 7'd0;
            end
         end
         ST_RINGING: begin
            cnt_d = cnt_inc[6:0];
            if (OK || !ALM_EN || (cnt_inc >= RING_LIM)) begin
               state_d = ST_DONE;
               ring_d  = 1'b0;
            end
         end
         ST_DONE: begin
            // Stay here until the matching second has passed to avoid re-triggering.
            ring_d = 1'b0;
            if (!match) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            ring_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         presc_q <= '0;
         hour_q  <= 7'd0;
         min_q   <= 7'd0;
         sec_q   <= 7'd0;
         tick_q  <= 1'b0;
         state_q <= ST_IDLE;
         ring_q  <= 1'b0;
         cnt_q   <= 7'd0;
      end else begin
         presc_q <= presc_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         tick_q  <= tick_d;
         state_q <= state_d;
         ring_q  <= ring_d;
         cnt_q   <= cnt_d;
      end
   end

   assign HOUR     = hour_q;
   assign MIN      = min_q;
   assign SEC      = sec_q;
   assign SEC_TICK = tick_q;
   assign RING     = ring_q;

endmodule
